// File: rtl/sign_scan_ctrl_pkg.sv
// Shared definitions for the sign scan sequencer: state encoding and index-width helper.
package sign_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index width for a bank of the given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sign_scan_ctrl_classify.sv
// Combinational sign classification of one two's-complement word.
module word_classify #(
    parameter int N = 8
) (
    input  logic [N-1:0] word,
    output logic         is_neg,
    output logic         is_zero
);

    assign is_neg  = word[N-1];
    assign is_zero = (word == '0);

endmodule

// File: rtl/sign_scan_ctrl.sv
// Owns a small word bank and, on start, walks it one entry per cycle counting
// negatives/zeros and locating the first negative entry.
module sign_scan_ctrl
    import sign_scan_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   neg_count,
    output logic [AW:0]   zero_count,
    output logic          found_neg,
    output logic [AW-1:0] first_neg_idx
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [N-1:0]  bank [DEPTH];
    logic [AW-1:0] idx;
    logic [AW:0]   run_neg;
    logic [AW:0]   run_zero;
    logic          run_found;
    logic [AW-1:0] run_idx;

    logic          is_neg;
    logic          is_zero;
    logic [AW:0]   neg_next;
    logic [AW:0]   zero_next;
    logic          found_next;
    logic [AW-1:0] first_next;

    word_classify #(.N(N)) u_classify (
        .word    (bank[idx]),
        .is_neg  (is_neg),
        .is_zero (is_zero)
    );

    // Running totals including the word under the index this cycle.
    assign neg_next   = run_neg + {{AW{1'b0}}, is_neg};
    assign zero_next  = run_zero + {{AW{1'b0}}, is_zero};
    assign found_next = run_found | is_neg;
    assign first_next = run_found ? run_idx : (is_neg ? idx : '0);

    // Writes only land while idle, so a scan always sees a frozen bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (state == S_IDLE && wr_en && int'(wr_addr) < DEPTH) begin
            bank[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            run_neg       <= '0;
            run_zero      <= '0;
            run_found     <= 1'b0;
            run_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            neg_count     <= '0;
            zero_count    <= '0;
            found_neg     <= 1'b0;
            first_neg_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_SCAN;
                        busy      <= 1'b1;
                        idx       <= '0;
                        run_neg   <= '0;
                        run_zero  <= '0;
                        run_found <= 1'b0;
                        run_idx   <= '0;
                    end
                end
                S_SCAN: begin
                    run_neg   <= neg_next;
                    run_zero  <= zero_next;
                    run_found <= found_next;
                    run_idx   <= first_next;
                    if (idx == LAST) begin
                        state         <= S_DONE;
                        done          <= 1'b1;
                        neg_count     <= neg_next;
                        zero_count    <= zero_next;
                        found_neg     <= found_next;
                        first_neg_idx <= first_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_scan_ctrl.sv
// Self-checking bench for sign_scan_ctrl against a behavioural bank model.
module tb_sign_scan_ctrl;

    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW:0]   neg_count;
    logic [AW:0]   zero_count;
    logic          found_neg;
    logic [AW-1:0] first_neg_idx;

    int tests = 0;
    int errors = 0;
    logic signed [N-1:0] mb [DEPTH];

    sign_scan_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .neg_count(neg_count),
        .zero_count(zero_count), .found_neg(found_neg), .first_neg_idx(first_neg_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_scan(output int nn, output int nz, output bit fnd, output int fi);
        nn = 0; nz = 0; fnd = 0; fi = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mb[i] < 0) begin
                if (!fnd) fi = i;
                fnd = 1;
                nn++;
            end else if (mb[i] == 0) begin
                nz++;
            end
        end
    endfunction

    task automatic write_word(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = N'(d);
        tick();
        wr_en = 1'b0;
        mb[a] = N'(d);
    endtask

    task automatic check_model(input string nm);
        int nn, nz, fi;
        bit fnd;
        ref_scan(nn, nz, fnd, fi);
        tests++; if (int'(neg_count) != nn) begin errors++; $display("FAIL %s neg_count got %0d want %0d", nm, neg_count, nn); end
        tests++; if (int'(zero_count) != nz) begin errors++; $display("FAIL %s zero_count got %0d want %0d", nm, zero_count, nz); end
        tests++; if (found_neg !== fnd) begin errors++; $display("FAIL %s found_neg got %0b want %0b", nm, found_neg, fnd); end
        tests++; if (int'(first_neg_idx) != fi) begin errors++; $display("FAIL %s first_neg_idx got %0d want %0d", nm, first_neg_idx, fi); end
    endtask

    // Start a scan and wait for done; leaves the DUT back in IDLE.
    task automatic run_scan(input string nm);
        int lat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %0b want 1", nm, busy); end
        while (done !== 1'b1 && lat < 50) begin tick(); lat++; end
        tests++; if (lat != DEPTH) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, DEPTH); end
        check_model(nm);
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s back_to_idle busy=%0b done=%0b want 0 0", nm, busy, done); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mb[i] = '0;
        tests++; if ({busy, done, neg_count, zero_count, found_neg, first_neg_idx} !== '0) begin
            errors++; $display("FAIL reset_state got busy=%0b done=%0b neg=%0d zero=%0d want all 0", busy, done, neg_count, zero_count);
        end
        for (int i = 0; i < DEPTH; i++) write_word(i, (i % 2) ? -5 : 9);
        run_scan("pre_reset");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || neg_count !== '0 || first_neg_idx !== '0 || found_neg !== 1'b0) begin
            errors++; $display("FAIL reset_midscan busy=%0b done=%0b neg=%0d first=%0d want 0", busy, done, neg_count, first_neg_idx);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mb[i] = '0;
        run_scan("bank_cleared");
        tests++; if (int'(zero_count) != DEPTH) begin errors++; $display("FAIL bank_zero zero_count got %0d want %0d", zero_count, DEPTH); end
    endtask

    task automatic test_mixed();
        int vals [DEPTH] = '{5, -3, 0, 127, -128, 0, 1, -1};
        int lat = 0;
        bit held = 1;
        for (int i = 0; i < DEPTH; i++) write_word(i, vals[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Previous (all-zero bank) results must stay visible while scanning.
        while (done !== 1'b1 && lat < 50) begin
            if (neg_count !== '0 || int'(zero_count) != DEPTH) held = 0;
            tick(); lat++;
        end
        tests++; if (!held) begin errors++; $display("FAIL mixed_hold_during_scan results changed before done"); end
        tests++; if (lat + 1 != 9) begin errors++; $display("FAIL mixed_latency got %0d want 9", lat + 1); end
        tests++; if (neg_count !== 4'd3 || zero_count !== 4'd2 || found_neg !== 1'b1 || first_neg_idx !== 3'd1) begin
            errors++; $display("FAIL mixed_fixed neg=%0d zero=%0d found=%0b first=%0d want 3 2 1 1", neg_count, zero_count, found_neg, first_neg_idx);
        end
        check_model("mixed");
        tick();
    endtask

    task automatic test_all_pos();
        for (int i = 0; i < DEPTH; i++) write_word(i, 1);
        run_scan("all_pos");
        tests++; if (neg_count !== '0 || zero_count !== '0 || found_neg !== 1'b0 || first_neg_idx !== '0) begin
            errors++; $display("FAIL all_pos_fixed neg=%0d zero=%0d found=%0b first=%0d want 0 0 0 0", neg_count, zero_count, found_neg, first_neg_idx);
        end
    endtask

    task automatic test_all_neg_restart();
        int pulses = 0;
        for (int i = 0; i < DEPTH; i++) write_word(i, 'h80);
        start = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        start = 1'b0;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        tests++; if (pulses != 1) begin errors++; $display("FAIL restart_pulses got %0d want 1", pulses); end
        tests++; if (int'(neg_count) != DEPTH || first_neg_idx !== '0) begin
            errors++; $display("FAIL all_neg neg=%0d first=%0d want %0d 0", neg_count, first_neg_idx, DEPTH);
        end
        check_model("all_neg");
    endtask

    task automatic test_write_during_scan();
        for (int i = 0; i < DEPTH; i++) write_word(i, 3 + i);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = -8'sd7;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) tick();
        run_scan("wr_busy_ignored");
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = -8'sd7; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        mb[2] = -8'sd7;
        for (int c = 0; c < 50 && done !== 1'b1; c++) tick();
        tests++; if (first_neg_idx !== 3'd2 || neg_count !== 4'd1) begin
            errors++; $display("FAIL wr_with_start first=%0d neg=%0d want 2 1", first_neg_idx, neg_count);
        end
        check_model("wr_with_start");
        tick();
    endtask

    task automatic test_back_to_back();
        int nn, nz, fi, ndone, last, bad;
        bit fnd;
        ref_scan(nn, nz, fnd, fi);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (int'(neg_count) != nn || int'(zero_count) != nz || found_neg !== fnd || int'(first_neg_idx) != fi || busy !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad != 0) begin errors++; $display("FAIL idle_hold got %0d bad cycles want 0", bad); end
        start = 1'b1;
        ndone = 0; last = -1; bad = 0;
        for (int c = 0; c < 4 * (DEPTH + 2) + 2; c++) begin
            tick();
            if (done === 1'b1) begin
                if (last >= 0 && c - last != DEPTH + 2) bad++;
                last = c; ndone++;
            end
        end
        start = 1'b0;
        tests++; if (ndone < 3 || bad != 0) begin errors++; $display("FAIL back_to_back pulses=%0d bad_gaps=%0d want >=3 and 0", ndone, bad); end
        for (int c = 0; c < 2 * DEPTH + 4; c++) tick();
        check_model("after_b2b");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                case ($urandom_range(0, 4))
                    0: write_word(i, 0);
                    1: write_word(i, -128);
                    2: write_word(i, 127);
                    3: write_word(i, -1);
                    default: write_word(i, int'($urandom_range(0, 255)));
                endcase
            end
            run_scan($sformatf("random%0d", it));
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_mixed();
        test_all_pos();
        test_all_neg_restart();
        test_write_during_scan();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
